// File: rtl/alu_result_checker.sv
// alu_result_checker
// Response checker for the tt_um_allanrodas74 ALU port. Each accepted
// stimulus byte is decoded into its expected ALU result, delayed LATENCY
// cycles to line up with the DUT output, and compared. Checks and
// mismatches are counted and pass/fail is reported once NUM_VECTORS checks
// have drained.
//
// Optional feature: define ALU_CHK_FIRSTFAIL_EN to latch the stimulus and
// DUT result of the first mismatch of a run on fail_stim / fail_got.
// Without it both outputs are tied to 0.
module alu_result_checker #(
    parameter int LATENCY     = 1,
    parameter int NUM_VECTORS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stim_valid,
    input  logic [7:0] stim,
    input  logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] chk_count,
    output logic [7:0] err_count,
    output logic [7:0] fail_stim,
    output logic [7:0] fail_got
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] NUM_VEC_C = 8'(NUM_VECTORS);

    state_t            state_r;
    state_t            next_state_s;
    logic [7:0]        acc_count_r;
    logic [7:0]        chk_count_r;
    logic [7:0]        err_count_r;
    logic [7:0]        exp_pipe_r [LATENCY];
    logic [LATENCY-1:0] vld_pipe_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic              start_run_s;
    logic              accept_s;
    logic              check_s;
    logic              mismatch_s;
    logic              pipe_empty_s;

    // Expected ALU result: a (4 bit) and b (2 bit) zero-extended to 8 bits.
    function automatic logic [7:0] calc_expected(input logic [7:0] s);
        logic [7:0] a_v;
        logic [7:0] b_v;
        logic [7:0] r_v;
        a_v = {4'h0, s[3:0]};
        b_v = {6'b000000, s[5:4]};
        case (s[7:6])
            2'b00:   r_v = a_v + b_v;
            2'b01:   r_v = a_v - b_v;
            2'b10:   r_v = a_v & b_v;
            2'b11:   r_v = a_v | b_v;
            default: r_v = 8'h00;
        endcase
        return r_v;
    endfunction

    // Per-cycle qualifiers: run start, vector acceptance and pipe-exit check.
    always_comb begin
        start_run_s  = start && (state_r != ST_RUN);
        accept_s     = (state_r == ST_RUN) && stim_valid && (acc_count_r < NUM_VEC_C);
        check_s      = (state_r == ST_RUN) && vld_pipe_r[LATENCY-1];
        mismatch_s   = check_s && (result != exp_pipe_r[LATENCY-1]);
        pipe_empty_s = (vld_pipe_r == {LATENCY{1'b0}});
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((chk_count_r == NUM_VEC_C) && pipe_empty_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Expected-value pipe: entry 0 loads on acceptance, last entry is checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                exp_pipe_r[i] <= 8'h00;
            end
        end else if (start_run_s) begin
            vld_pipe_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                exp_pipe_r[i] <= 8'h00;
            end
        end else begin
            vld_pipe_r[0] <= accept_s;
            exp_pipe_r[0] <= calc_expected(stim);
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                exp_pipe_r[i] <= exp_pipe_r[i-1];
            end
        end
    end

    // Accepted/check/error counters; the error count saturates at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_count_r <= 8'h00;
            chk_count_r <= 8'h00;
            err_count_r <= 8'h00;
        end else if (start_run_s) begin
            acc_count_r <= 8'h00;
            chk_count_r <= 8'h00;
            err_count_r <= 8'h00;
        end else begin
            if (accept_s) begin
                acc_count_r <= acc_count_r + 8'd1;
            end
            if (check_s) begin
                chk_count_r <= chk_count_r + 8'd1;
            end
            if (mismatch_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    // Status flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_RUN);
            done_r <= (next_state_s == ST_DONE);
            pass_r <= (next_state_s == ST_DONE) && (err_count_r == 8'h00);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign chk_count = chk_count_r;
    assign err_count = err_count_r;

`ifdef ALU_CHK_FIRSTFAIL_EN
    logic [7:0] stim_pipe_r [LATENCY];
    logic [7:0] fail_stim_r;
    logic [7:0] fail_got_r;

    // Stimulus travels alongside its expected value so a failure can be reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stim_pipe_r[i] <= 8'h00;
            end
        end else begin
            stim_pipe_r[0] <= stim;
            for (int i = 1; i < LATENCY; i++) begin
                stim_pipe_r[i] <= stim_pipe_r[i-1];
            end
        end
    end

    // Latch only the first mismatch of a run (error count still zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_stim_r <= 8'h00;
            fail_got_r  <= 8'h00;
        end else if (start_run_s) begin
            fail_stim_r <= 8'h00;
            fail_got_r  <= 8'h00;
        end else if (mismatch_s && (err_count_r == 8'h00)) begin
            fail_stim_r <= stim_pipe_r[LATENCY-1];
            fail_got_r  <= result;
        end
    end

    assign fail_stim = fail_stim_r;
    assign fail_got  = fail_got_r;
`else
    assign fail_stim = 8'h00;
    assign fail_got  = 8'h00;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three checker instances with different
// LATENCY / NUM_VECTORS, each fed by a small fake ALU whose output can be
// forced per vector, plus a queue-based reference model per instance.
module tb_alu_result_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]      start_r  = 3'b000;
    logic [2:0]      sv_r     = 3'b000;
    logic [2:0][7:0] stim_r   = '0;
    logic [2:0]      bad_r    = 3'b000;
    logic [2:0][7:0] badval_r = '0;

    wire [2:0]      busy_w, done_w, pass_w;
    wire [2:0][7:0] chk_w, err_w, fs_w, fg_w, result_w;
    wire [2:0]      m_busy, m_done, m_pass;
    wire [2:0][7:0] m_chk, m_err, m_fs, m_fg;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [7:0] s);
        int a;
        int b;
        int r;
        a = int'(s[3:0]);
        b = int'(s[5:4]);
        case (s[7:6])
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return 8'(r);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_unit
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int N = (g == 0) ? 2 : ((g == 1) ? 16 : 255);

        logic [7:0] alu_p [4] = '{default: 8'h00};
        int st = 0;
        int acc = 0;
        int chk = 0;
        int err = 0;
        int cyc = 0;
        logic [7:0] fs = 8'h00;
        logic [7:0] fg = 8'h00;
        int         q_due [$];
        logic [7:0] q_exp [$];
        logic [7:0] q_stim [$];

        alu_result_checker #(.LATENCY(L), .NUM_VECTORS(N)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_r[g]),
            .stim_valid (sv_r[g]),
            .stim       (stim_r[g]),
            .result     (result_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .pass       (pass_w[g]),
            .chk_count  (chk_w[g]),
            .err_count  (err_w[g]),
            .fail_stim  (fs_w[g]),
            .fail_got   (fg_w[g])
        );

        // Fake ALU: L-cycle delay of the reference result or a forced value.
        always @(posedge clk) begin
            alu_p[0] <= bad_r[g] ? badval_r[g] : ref_alu(stim_r[g]);
            for (int i = 1; i < 4; i++) alu_p[i] <= alu_p[i-1];
        end
        assign result_w[g] = alu_p[L-1];

        // Reference model: queue of (due cycle, expected, stimulus).
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                st = 0; acc = 0; chk = 0; err = 0; fs = 8'h00; fg = 8'h00;
                q_due.delete(); q_exp.delete(); q_stim.delete();
            end else begin
                cyc++;
                if (st != 1) begin
                    if (start_r[g]) begin
                        st = 1; acc = 0; chk = 0; err = 0; fs = 8'h00; fg = 8'h00;
                        q_due.delete(); q_exp.delete(); q_stim.delete();
                    end
                end else if (chk == N && q_due.size() == 0) begin
                    st = 2;
                end else begin
                    if (q_due.size() > 0 && q_due[0] == cyc) begin
                        chk++;
                        if (result_w[g] !== q_exp[0]) begin
                            if (err == 0) begin
                                fs = q_stim[0];
                                fg = result_w[g];
                            end
                            if (err < 255) err++;
                        end
                        void'(q_due.pop_front());
                        void'(q_exp.pop_front());
                        void'(q_stim.pop_front());
                    end
                    if (sv_r[g] && acc < N) begin
                        q_due.push_back(cyc + L);
                        q_exp.push_back(ref_alu(stim_r[g]));
                        q_stim.push_back(stim_r[g]);
                        acc++;
                    end
                end
            end
        end

        assign m_busy[g] = (st == 1);
        assign m_done[g] = (st == 2);
        assign m_pass[g] = (st == 2) && (err == 0);
        assign m_chk[g]  = 8'(chk);
        assign m_err[g]  = 8'(err);
`ifdef ALU_CHK_FIRSTFAIL_EN
        assign m_fs[g] = fs;
        assign m_fg[g] = fg;
`else
        assign m_fs[g] = 8'h00;
        assign m_fg[g] = 8'h00;
`endif
    end

    task automatic check8(input string nm, input int g, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, g, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 3; g++) begin
            check8("busy",      g, {7'b0, busy_w[g]}, {7'b0, m_busy[g]});
            check8("done",      g, {7'b0, done_w[g]}, {7'b0, m_done[g]});
            check8("pass",      g, {7'b0, pass_w[g]}, {7'b0, m_pass[g]});
            check8("chk_count", g, chk_w[g], m_chk[g]);
            check8("err_count", g, err_w[g], m_err[g]);
            check8("fail_stim", g, fs_w[g], m_fs[g]);
            check8("fail_got",  g, fg_w[g], m_fg[g]);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        compare_all();
    end

    task automatic do_start(input int g);
        start_r[g] = 1'b1;
        @(negedge clk);
        start_r[g] = 1'b0;
    endtask

    task automatic send_vec(input int g, input logic [7:0] s, input logic b, input logic [7:0] bv);
        sv_r[g] = 1'b1; stim_r[g] = s; bad_r[g] = b; badval_r[g] = bv;
        @(negedge clk);
        sv_r[g] = 1'b0; bad_r[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int maxc);
        int k;
        k = 0;
        while (done_w[g] !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (done_w[g] !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout dut%0d got=0 exp=1", g);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check8("rst_busy", 0, {7'b0, busy_w[0]}, 8'h00);
        check8("rst_chk",  0, chk_w[0], 8'h00);

        // Two correct vectors, DUT outputs given as hand-computed literals.
        do_start(0);
        send_vec(0, 8'h03, 1'b1, 8'h03);
        send_vec(0, 8'h48, 1'b1, 8'h08);
        wait_done(0, 20);
        check8("t1_chk",  0, chk_w[0], 8'd2);
        check8("t1_err",  0, err_w[0], 8'd0);
        check8("t1_done", 0, {7'b0, done_w[0]}, 8'd1);
        check8("t1_pass", 0, {7'b0, pass_w[0]}, 8'd1);

        // Subtraction wrap: FE is right, 02 is wrong.
        do_start(0);
        send_vec(0, 8'h71, 1'b1, 8'hFE);
        send_vec(0, 8'h71, 1'b1, 8'h02);
        wait_done(0, 20);
        check8("t2_chk",  0, chk_w[0], 8'd2);
        check8("t2_err",  0, err_w[0], 8'd1);
        check8("t2_pass", 0, {7'b0, pass_w[0]}, 8'd0);
`ifdef ALU_CHK_FIRSTFAIL_EN
        check8("t2_fstim", 0, fs_w[0], 8'h71);
        check8("t2_fgot",  0, fg_w[0], 8'h02);
`else
        check8("t2_fstim", 0, fs_w[0], 8'h00);
        check8("t2_fgot",  0, fg_w[0], 8'h00);
`endif

        // LATENCY 3: 16 back-to-back, 2 extra pulses, done 4 cycles later.
        do_start(1);
        for (int i = 0; i < 16; i++) send_vec(1, 8'(i * 41 + 19), 1'b0, 8'h00);
        k = 0;
        while (done_w[1] !== 1'b1 && k < 20) begin
            sv_r[1] = (k < 2); stim_r[1] = 8'h55;
            @(negedge clk);
            k++;
        end
        sv_r[1] = 1'b0;
        check8("t3_done_lat", 1, 8'(k), 8'd4);
        check8("t3_chk",  1, chk_w[1], 8'd16);
        check8("t3_err",  1, err_w[1], 8'd0);
        check8("t3_pass", 1, {7'b0, pass_w[1]}, 8'd1);

        // Gapped vectors with a start pulse mid-run that must be ignored.
        do_start(1);
        for (int i = 0; i < 16; i++) begin
            v = 8'(i * 23 + 7);
            if (i == 5) do_start(1);
            send_vec(1, v, (i == 2), ~ref_alu(v));
            @(negedge clk);
        end
        wait_done(1, 20);
        check8("t6_chk", 1, chk_w[1], 8'd16);
        check8("t6_err", 1, err_w[1], 8'd1);

        // Asynchronous reset mid-run, then a clean rerun.
        do_start(1);
        for (int i = 0; i < 6; i++) begin
            v = 8'(i * 59 + 3);
            send_vec(1, v, (i == 0), ~ref_alu(v));
        end
        #2 rst = 1'b1;
        #1;
        check8("t5_busy", 1, {7'b0, busy_w[1]}, 8'd0);
        check8("t5_chk",  1, chk_w[1], 8'd0);
        check8("t5_err",  1, err_w[1], 8'd0);
        check8("t5_done0", 0, {7'b0, done_w[0]}, 8'd0);
        check8("t5_err0",  0, err_w[0], 8'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(1);
        for (int i = 0; i < 16; i++) send_vec(1, 8'(i * 77 + 1), 1'b0, 8'h00);
        wait_done(1, 20);
        check8("t5_rerun_chk",  1, chk_w[1], 8'd16);
        check8("t5_rerun_err",  1, err_w[1], 8'd0);
        check8("t5_rerun_pass", 1, {7'b0, pass_w[1]}, 8'd1);

        // 255 vectors, all answered with 00 against nonzero expectations.
        do_start(2);
        for (int i = 0; i < 255; i++) begin
            v = {2'b11, i[1:0], 4'(i % 15 + 1)};
            send_vec(2, v, 1'b1, 8'h00);
        end
        wait_done(2, 20);
        check8("t4_chk",  2, chk_w[2], 8'd255);
        check8("t4_err",  2, err_w[2], 8'd255);
        check8("t4_pass", 2, {7'b0, pass_w[2]}, 8'd0);
`ifdef ALU_CHK_FIRSTFAIL_EN
        check8("t4_fstim", 2, fs_w[2], 8'hC1);
`else
        check8("t4_fstim", 2, fs_w[2], 8'h00);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
